// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared types and constants for the MIPS CPU and its
// instruction sequencer.
//   inst_t / word_t   : 32-bit instruction and data words
//   OP_* / REG_*      : opcode and register-number constants
//   seq_state_t       : sequencer state encoding
//   NOP_INST          : instruction driven while nothing is issued
//   make_itype()      : assembles an I-type instruction word
package mips_cpu_pkg;

  typedef logic [31:0] inst_t;
  typedef logic [31:0] word_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_T0   = 5'd8;
  localparam logic [4:0] REG_T7   = 5'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  localparam inst_t NOP_INST = 32'h0;

  function automatic inst_t make_itype(input logic [5:0]  op,
                                       input logic [4:0]  rs,
                                       input logic [4:0]  rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/prog_buffer.sv
// prog_buffer: DEPTH x inst_t program store, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational)
module prog_buffer
  import mips_cpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  inst_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output inst_t         rdata_o
);

  inst_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_sequencer.sv
// inst_sequencer: holds a small program loaded by a host and feeds it to the
// CPU one instruction per cycle (continuous run or single step), then drains
// for RESULT_LAT cycles so the last results can be traced.
//   cpu_clk_50M / cpu_rst           : clock, synchronous active-high reset
//   load_valid/load_inst/load_ready : program load handshake (IDLE only)
//   clr_prog                        : empty the program (IDLE only)
//   cmd_run/cmd_step/cmd_halt       : issue control
//   loop_en                         : wrap to entry 0 instead of stopping
//   en/outer_inst                   : instruction presented to the CPU
//   peek1/peek2                     : CPU debug words
//   trace_valid/trace_peek1/2       : peeks captured RESULT_LAT after an issue
//   state/prog_cnt/issue_cnt        : status
//
// state | meaning
// IDLE  | loads and commands accepted
// RUN   | issue every cycle until end of program or halt
// STEP  | issue a single instruction
// DRAIN | wait RESULT_LAT cycles for results, commands ignored
module inst_sequencer
  import mips_cpu_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int RESULT_LAT = 5
) (
  input  logic                   cpu_clk_50M,
  input  logic                   cpu_rst,
  input  logic                   load_valid,
  input  inst_t                  load_inst,
  output logic                   load_ready,
  input  logic                   clr_prog,
  input  logic                   cmd_run,
  input  logic                   cmd_step,
  input  logic                   cmd_halt,
  input  logic                   loop_en,
  output logic                   en,
  output inst_t                  outer_inst,
  input  word_t                  peek1,
  input  word_t                  peek2,
  output logic                   trace_valid,
  output word_t                  trace_peek1,
  output word_t                  trace_peek2,
  output seq_state_t             state,
  output logic [$clog2(DEPTH):0] prog_cnt,
  output logic [15:0]            issue_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(RESULT_LAT - 1);

  seq_state_t            state_q;
  logic [AW-1:0]         pc_q;
  logic [CW-1:0]         prog_cnt_q, prog_cnt_d;
  logic [15:0]           issue_cnt_q;
  logic                  en_q, load_ready_q, trace_valid_q;
  inst_t                 outer_inst_q;
  word_t                 trace_peek1_q, trace_peek2_q;
  logic [RESULT_LAT-1:0] trace_sr_q;
  logic [DW-1:0]         drain_cnt_q;

  logic          idle, clr_fire, load_fire, cmd_ok, issue_now, pc_last;
  logic [AW-1:0] pc_next;
  inst_t         rd_inst;

  always_comb begin
    idle      = (state_q == IDLE);
    clr_fire  = idle && clr_prog;
    load_fire = idle && load_valid && load_ready_q && !clr_prog;
    // A clear in the same cycle empties the program, so commands must not fire.
    cmd_ok    = idle && !clr_prog && (prog_cnt_q != '0);
    issue_now = ((state_q == RUN) && !cmd_halt) || (state_q == STEP);
    pc_last   = (CW'(pc_q) == (prog_cnt_q - CW'(1)));
    pc_next   = pc_last ? '0 : pc_q + AW'(1);
    prog_cnt_d = prog_cnt_q;
    if (clr_fire)       prog_cnt_d = '0;
    else if (load_fire) prog_cnt_d = prog_cnt_q + CW'(1);
  end

  prog_buffer #(.DEPTH(DEPTH), .AW(AW)) u_prog_buffer (
    .clk_i   (cpu_clk_50M),
    .we_i    (load_fire && !cpu_rst),
    .waddr_i (prog_cnt_q[AW-1:0]),
    .wdata_i (load_inst),
    .raddr_i (pc_q),
    .rdata_o (rd_inst)
  );

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      prog_cnt_q    <= '0;
      issue_cnt_q   <= '0;
      en_q          <= 1'b0;
      outer_inst_q  <= NOP_INST;
      load_ready_q  <= 1'b1;
      trace_valid_q <= 1'b0;
      trace_peek1_q <= '0;
      trace_peek2_q <= '0;
      trace_sr_q    <= '0;
      drain_cnt_q   <= '0;
    end else begin
      prog_cnt_q   <= prog_cnt_d;
      en_q         <= issue_now;
      outer_inst_q <= issue_now ? rd_inst : NOP_INST;
      if (issue_now) issue_cnt_q <= issue_cnt_q + 16'd1;

      // One flag per edge; the flag leaving the top marks a result now valid.
      trace_sr_q    <= (trace_sr_q << 1) | RESULT_LAT'(issue_now);
      trace_valid_q <= trace_sr_q[RESULT_LAT-1];
      if (trace_sr_q[RESULT_LAT-1]) begin
        trace_peek1_q <= peek1;
        trace_peek2_q <= peek2;
      end

      load_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_fire) pc_q <= '0;
          if (cmd_ok && cmd_run) begin
            state_q <= RUN;
            pc_q    <= '0;
          end else if (cmd_ok && cmd_step) begin
            state_q <= STEP;
          end else begin
            load_ready_q <= (prog_cnt_d < DEPTH_C);
          end
        end
        RUN: begin
          if (cmd_halt) begin
            state_q     <= DRAIN;
            drain_cnt_q <= DRAIN_INIT;
          end else begin
            pc_q <= pc_next;
            if (pc_last && !loop_en) begin
              state_q     <= DRAIN;
              drain_cnt_q <= DRAIN_INIT;
            end
          end
        end
        STEP: begin
          pc_q        <= pc_next;
          state_q     <= DRAIN;
          drain_cnt_q <= DRAIN_INIT;
        end
        DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q      <= IDLE;
            load_ready_q <= (prog_cnt_q < DEPTH_C);
          end else begin
            drain_cnt_q <= drain_cnt_q - DW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state       = state_q;
  assign prog_cnt    = prog_cnt_q;
  assign issue_cnt   = issue_cnt_q;
  assign en          = en_q;
  assign outer_inst  = outer_inst_q;
  assign load_ready  = load_ready_q;
  assign trace_valid = trace_valid_q;
  assign trace_peek1 = trace_peek1_q;
  assign trace_peek2 = trace_peek2_q;

endmodule

// File: tb/tb_inst_sequencer.sv
module tb_inst_sequencer;
  import mips_cpu_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT   = 5;

  logic       cpu_clk_50M = 1'b0;
  logic       cpu_rst = 1'b1;
  logic       load_valid = 1'b0;
  inst_t      load_inst = '0;
  logic       load_ready;
  logic       clr_prog = 1'b0, cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0;
  logic       loop_en = 1'b0;
  logic       en;
  inst_t      outer_inst;
  word_t      peek1 = '0, peek2 = '0;
  logic       trace_valid;
  word_t      trace_peek1, trace_peek2;
  seq_state_t state;
  logic [4:0] prog_cnt;
  logic [15:0] issue_cnt;

  inst_sequencer #(.DEPTH(DEPTH), .RESULT_LAT(LAT)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .load_valid  (load_valid),
    .load_inst   (load_inst),
    .load_ready  (load_ready),
    .clr_prog    (clr_prog),
    .cmd_run     (cmd_run),
    .cmd_step    (cmd_step),
    .cmd_halt    (cmd_halt),
    .loop_en     (loop_en),
    .en          (en),
    .outer_inst  (outer_inst),
    .peek1       (peek1),
    .peek2       (peek2),
    .trace_valid (trace_valid),
    .trace_peek1 (trace_peek1),
    .trace_peek2 (trace_peek2),
    .state       (state),
    .prog_cnt    (prog_cnt),
    .issue_cnt   (issue_cnt)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  int checks = 0, failures = 0;
  inst_t exp_q[$];
  int    trace_exp_q[$];
  int    edge_cnt = 0;
  word_t pk1_hist[64], pk2_hist[64];
  int    trace_seen = 0;

  // Reference program model: what was accepted, where a step resumes, total issues.
  inst_t prog_m[DEPTH];
  int    cnt_m = 0, pc_m = 0, issued_m = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  // Edge bookkeeping and peek values as the DUT samples them.
  always @(posedge cpu_clk_50M) begin
    edge_cnt++;
    pk1_hist[edge_cnt % 64] = peek1;
    pk2_hist[edge_cnt % 64] = peek2;
  end

  always @(posedge cpu_clk_50M) begin
    #1;
    peek1 = $urandom;
    peek2 = $urandom;
  end

  // Monitor: pops the expected issue stream and the expected trace edges.
  always @(negedge cpu_clk_50M) begin
    if (en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected: got %0h expected no issue", outer_inst);
      end else begin
        check("issue_inst", outer_inst, exp_q.pop_front());
      end
      trace_exp_q.push_back(edge_cnt + LAT);
    end else if (!cpu_rst) begin
      check("idle_nop", outer_inst, NOP_INST);
    end
    if (trace_valid === 1'b1) begin
      trace_seen++;
      checks++;
      if (trace_exp_q.size() == 0) begin
        failures++;
        $display("FAIL trace_unexpected: got pulse at edge %0d expected none", edge_cnt);
      end else begin
        check("trace_edge", edge_cnt, trace_exp_q.pop_front());
        check("trace_peek1", trace_peek1, pk1_hist[edge_cnt % 64]);
        check("trace_peek2", trace_peek2, pk2_hist[edge_cnt % 64]);
      end
    end
  end

  task automatic load_n(int n, bit pattern);
    inst_t inst;
    for (int i = 0; i < n; i++) begin
      inst = pattern ? make_itype(OP_ADDI, REG_ZERO, (i % 2) ? REG_T7 : REG_T0, 16'd127)
                     : inst_t'($urandom);
      check("load_ready", load_ready, (cnt_m < DEPTH) ? 1 : 0);
      load_valid = 1'b1;
      load_inst  = inst;
      tick();
      if (cnt_m < DEPTH) begin
        prog_m[cnt_m] = inst;
        cnt_m++;
      end
    end
    load_valid = 1'b0;
    check("prog_cnt", prog_cnt, cnt_m);
  endtask

  task automatic clear();
    clr_prog = 1'b1;
    tick();
    clr_prog = 1'b0;
    cnt_m = 0;
    pc_m  = 0;
    check("clr_prog_cnt", prog_cnt, 0);
  endtask

  task automatic wait_idle(output int ens, output int drains, output int span);
    int first, last;
    ens = 0; drains = 0; first = -1; last = -1;
    for (int k = 0; k < 200; k++) begin
      if (state == IDLE) begin
        span = (first < 0) ? 0 : last - first + 1;
        return;
      end
      if (en) begin
        ens++;
        if (first < 0) first = k;
        last = k;
      end
      if (state == DRAIN) drains++;
      tick();
    end
    span = 0;
    checks++;
    failures++;
    $display("FAIL wait_idle_timeout: got state %0d expected IDLE", state);
  endtask

  // Single pass through the whole program with loop_en=0.
  task automatic run_once(string tag);
    int ens, dr, span, t0;
    loop_en = 1'b0;
    for (int i = 0; i < cnt_m; i++) exp_q.push_back(prog_m[i]);
    issued_m += cnt_m;
    t0 = trace_seen;
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    check({tag, "_state_run"}, state, RUN);
    wait_idle(ens, dr, span);
    check({tag, "_en_count"}, ens, cnt_m);
    check({tag, "_en_contig"}, span, cnt_m);
    check({tag, "_drain_cycles"}, dr, LAT);
    check({tag, "_issue_cnt"}, issue_cnt, 16'(issued_m));
    tick(); tick();
    check({tag, "_trace_count"}, trace_seen - t0, cnt_m);
    pc_m = 0;
  endtask

  initial begin
    int ens, dr, span, n;
    tick();
    cpu_rst = 1'b0;
    check("rst_state", state, IDLE);
    check("rst_prog_cnt", prog_cnt, 0);
    check("rst_issue_cnt", issue_cnt, 0);
    check("rst_en", en, 0);
    check("rst_outer", outer_inst, NOP_INST);
    check("rst_trace_valid", trace_valid, 0);
    check("rst_trace_peek1", trace_peek1, 0);
    check("rst_load_ready", load_ready, 1);

    // Four alternating ADDI T0/T7, 127, single pass.
    load_n(4, 1'b1);
    run_once("run4");

    // Two-entry loop halted after ten issues.
    clear();
    load_n(2, 1'b0);
    loop_en = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(prog_m[i % 2]);
    issued_m += 10;
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && n < 10; k++) begin
      tick();
      if (en) n++;
    end
    check("loop_issues_before_halt", n, 10);
    cmd_halt = 1'b1;
    tick();
    cmd_halt = 1'b0;
    check("halt_no_issue", en, 0);
    check("halt_state", state, DRAIN);
    wait_idle(ens, dr, span);
    check("halt_issue_cnt", issue_cnt, 16'(issued_m));
    pc_m = 0;

    // Three entries, four single steps.
    clear();
    load_n(3, 1'b0);
    loop_en = 1'($urandom);
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back(prog_m[pc_m]);
      pc_m = (pc_m + 1) % cnt_m;
      issued_m++;
      cmd_step = 1'b1;
      tick();
      cmd_step = 1'b0;
      check("step_state", state, STEP);
      wait_idle(ens, dr, span);
      check("step_en_count", ens, 1);
      check("step_drain", dr, LAT);
    end
    check("step_issue_cnt", issue_cnt, 16'(issued_m));

    // Randomized program lengths.
    for (int r = 0; r < 3; r++) begin
      clear();
      load_n($urandom_range(1, DEPTH), 1'b0);
      run_once("rand");
    end

    // Overfill, then clear and try to run an empty program.
    clear();
    load_n(17, 1'b0);
    check("full_prog_cnt", prog_cnt, 16);
    check("full_load_ready", load_ready, 0);
    clear();
    check("clr_load_ready", load_ready, 1);
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("empty_run_state", state, IDLE);
      check("empty_run_en", en, 0);
      tick();
    end

    // Halt ignored in IDLE; run+step together enters RUN.
    load_n(2, 1'b0);
    cmd_halt = 1'b1;
    tick();
    cmd_halt = 1'b0;
    check("idle_halt_state", state, IDLE);
    check("idle_halt_en", en, 0);
    loop_en = 1'b0;
    for (int i = 0; i < 2; i++) exp_q.push_back(prog_m[i]);
    issued_m += 2;
    cmd_run = 1'b1;
    cmd_step = 1'b1;
    tick();
    cmd_run = 1'b0;
    cmd_step = 1'b0;
    check("runstep_state", state, RUN);
    wait_idle(ens, dr, span);
    check("runstep_en_count", ens, 2);
    tick(); tick();

    // Reset in the middle of a looping run.
    clear();
    load_n(3, 1'b0);
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(prog_m[i]);
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      tick();
      if (en) n++;
    end
    check("pre_reset_issues", n, 3);
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    trace_exp_q.delete();
    cnt_m = 0; pc_m = 0; issued_m = 0;
    for (int k = 0; k < 10; k++) begin
      check("rrst_en", en, 0);
      check("rrst_state", state, IDLE);
      check("rrst_prog_cnt", prog_cnt, 0);
      check("rrst_trace_valid", trace_valid, 0);
      tick();
    end
    check("rrst_issue_cnt", issue_cnt, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
